// File: rtl/imem_fetch_arbiter.sv
// ============================================================================
// imem_fetch_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Arbitrates the instruction fetches of two cores onto one shared,
//   combinational-read instruction memory. At most one fetch is accepted per
//   cycle. The winner is picked by a round-robin priority pointer. Each
//   accepted fetch returns a one-cycle response pulse in the next cycle.
//   A small BOOT/RUN/HALT state machine holds off grants after reset and
//   while a debug halt is requested.
//
// Parameters:
//   DEPTH        number of 32-bit words in the shared instruction memory
//   BOOT_CYCLES  cycles after reset release before the first grant
//   NOP_INSTR    word returned for a misaligned or out-of-range fetch
//
// Ports:
//   i_clk              clock; all state updates on the rising edge
//   i_reset            synchronous, active-high reset
//   i_halt             debug halt request; blocks new grants while high
//   i_reqN_valid       core N fetch request (N = 0, 1)
//   i_reqN_addr  [31:0] core N byte address
//   o_reqN_ready       core N request accepted this cycle
//   o_rspN_valid       one-cycle response pulse for core N
//   o_rspN_instr [31:0] fetched instruction for core N
//   o_rspN_err         response flags a misaligned or out-of-range address
//   o_mem_addr   [31:0] byte address driven to the instruction memory
//   i_mem_instr  [31:0] memory word for o_mem_addr, same cycle
//   o_halted           high while the state machine is in HALT
//   o_perf_grant0/1, o_perf_conflict [31:0]  performance counters
//
// Configuration macro:
//   IMEM_ARB_PERF_EN   when defined, the three performance counters are
//                      built and saturate at 32'hFFFFFFFF; when undefined
//                      they read as constant zero.
// ============================================================================
module imem_fetch_arbiter #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_addr,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_addr,
    output logic        o_req1_ready,
    output logic        o_rsp0_valid,
    output logic [31:0] o_rsp0_instr,
    output logic        o_rsp0_err,
    output logic        o_rsp1_valid,
    output logic [31:0] o_rsp1_instr,
    output logic        o_rsp1_err,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_instr,
    output logic        o_halted,
    output logic [31:0] o_perf_grant0,
    output logic [31:0] o_perf_grant1,
    output logic [31:0] o_perf_conflict
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int unsigned CNT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
    localparam logic [CNT_W-1:0] BOOT_LAST =
        CNT_W'((BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_bootCount;
    logic             w_running;
    logic             w_canGrant;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_err0;
    logic             w_err1;
    logic             r_prio;
    logic             r_rspValid0;
    logic             r_rspValid1;
    logic [31:0]      r_rspInstr0;
    logic [31:0]      r_rspInstr1;
    logic             r_rspErr0;
    logic             r_rspErr1;

    // State register and boot counter. The counter only advances in BOOT;
    // it stops at its last value, and the state machine then leaves BOOT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_BOOT;
            r_bootCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_BOOT && r_bootCount != BOOT_LAST) begin
                r_bootCount <= r_bootCount + CNT_W'(1);
            end
        end
    end

    // Next-state logic. With BOOT_CYCLES of zero, BOOT behaves exactly like
    // RUN so that grants are possible in the very first cycle after reset.
    always_comb begin
        w_nextState = r_state;
        w_running   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                if (BOOT_CYCLES == 0) begin
                    w_running   = 1'b1;
                    w_nextState = i_halt ? ST_HALT : ST_RUN;
                end else if (r_bootCount == BOOT_LAST) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_running = 1'b1;
                if (i_halt) begin
                    w_nextState = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!i_halt) begin
                    w_nextState = ST_RUN;
                end
            end
            default: begin
                w_nextState = ST_BOOT;
            end
        endcase
    end

    // A halt sampled in RUN already suppresses the grant of that cycle.
    // Reset is folded in so that ready stays low throughout reset.
    assign w_canGrant = w_running && !i_halt && !i_reset;

    // r_prio = 0 favours core 0 on a conflict, 1 favours core 1.
    assign w_grant0 = w_canGrant && i_req0_valid && (!i_req1_valid || !r_prio);
    assign w_grant1 = w_canGrant && i_req1_valid && (!i_req0_valid ||  r_prio);

    assign w_err0 = (i_req0_addr[1:0] != 2'b00) || ({2'b00, i_req0_addr[31:2]} >= DEPTH_W);
    assign w_err1 = (i_req1_addr[1:0] != 2'b00) || ({2'b00, i_req1_addr[31:2]} >= DEPTH_W);

    assign o_mem_addr   = w_grant1 ? i_req1_addr : i_req0_addr;
    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;

    // Response capture and priority pointer. Data and error flag are loaded
    // only on a grant, so they hold until the next response to that core.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prio      <= 1'b0;
            r_rspValid0 <= 1'b0;
            r_rspValid1 <= 1'b0;
            r_rspInstr0 <= '0;
            r_rspInstr1 <= '0;
            r_rspErr0   <= 1'b0;
            r_rspErr1   <= 1'b0;
        end else begin
            r_rspValid0 <= w_grant0;
            r_rspValid1 <= w_grant1;
            if (w_grant0) begin
                r_rspInstr0 <= w_err0 ? NOP_INSTR : i_mem_instr;
                r_rspErr0   <= w_err0;
                r_prio      <= 1'b1;
            end else if (w_grant1) begin
                r_prio      <= 1'b0;
            end
            if (w_grant1) begin
                r_rspInstr1 <= w_err1 ? NOP_INSTR : i_mem_instr;
                r_rspErr1   <= w_err1;
            end
        end
    end

    // Registered outputs are masked while reset is high, which also cancels
    // a response that was due in the first reset cycle.
    assign o_rsp0_valid = r_rspValid0 && !i_reset;
    assign o_rsp1_valid = r_rspValid1 && !i_reset;
    assign o_rsp0_instr = i_reset ? 32'h0 : r_rspInstr0;
    assign o_rsp1_instr = i_reset ? 32'h0 : r_rspInstr1;
    assign o_rsp0_err   = r_rspErr0 && !i_reset;
    assign o_rsp1_err   = r_rspErr1 && !i_reset;
    assign o_halted     = (r_state == ST_HALT) && !i_reset;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] r_perfGrant0;
    logic [31:0] r_perfGrant1;
    logic [31:0] r_perfConflict;
    logic        w_conflict;

    assign w_conflict = w_running && i_req0_valid && i_req1_valid && !i_reset;

    // Saturating event counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perfGrant0   <= '0;
            r_perfGrant1   <= '0;
            r_perfConflict <= '0;
        end else begin
            if (w_grant0 && r_perfGrant0 != 32'hFFFFFFFF) begin
                r_perfGrant0 <= r_perfGrant0 + 32'd1;
            end
            if (w_grant1 && r_perfGrant1 != 32'hFFFFFFFF) begin
                r_perfGrant1 <= r_perfGrant1 + 32'd1;
            end
            if (w_conflict && r_perfConflict != 32'hFFFFFFFF) begin
                r_perfConflict <= r_perfConflict + 32'd1;
            end
        end
    end

    assign o_perf_grant0   = i_reset ? 32'h0 : r_perfGrant0;
    assign o_perf_grant1   = i_reset ? 32'h0 : r_perfGrant1;
    assign o_perf_conflict = i_reset ? 32'h0 : r_perfConflict;
`else
    assign o_perf_grant0   = 32'h0;
    assign o_perf_grant1   = 32'h0;
    assign o_perf_conflict = 32'h0;
`endif

endmodule

// File: doc/imem_fetch_arbiter.md
IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

Interface
REQ-001 Parameter DEPTH, default 32, meaning number of 32-bit words in the shared instruction memory.
REQ-002 Parameter BOOT_CYCLES, default 4, meaning post-reset cycles before any grant.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, meaning word returned on erroneous fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 halt  input  1  debug halt request; blocks new grants while high.
REQ-007 reqN_valid  input  1  core N (N=0,1) fetch request.
REQ-008 reqN_addr  input  32  core N byte address; held stable while reqN_valid and not reqN_ready.
REQ-009 reqN_ready  output  1  core N request accepted this cycle.
REQ-010 rspN_valid  output  1  one-cycle pulse: response for core N.
REQ-011 rspN_instr  output  32  fetched instruction for core N.
REQ-012 rspN_err  output  1  response flags misaligned or out-of-range address.
REQ-013 mem_addr  output  32  byte address driven to the combinational-read instruction memory.
REQ-014 mem_instr  input  32  word returned by the memory for mem_addr in the same cycle.
REQ-015 halted  output  1  high while FSM is in HALT.
REQ-016 perf_grant0, perf_grant1, perf_conflict  output  32 each  performance counters (see Configuration).

Function
REQ-017 FSM states BOOT, RUN, HALT; grants are issued only in RUN.
REQ-018 BOOT -> RUN after exactly BOOT_CYCLES cycles counted from reset deassertion; BOOT_CYCLES=0 enters RUN on the first cycle.
REQ-019 RUN -> HALT on the cycle halt is sampled high; no grant is issued in that cycle.
REQ-020 HALT -> RUN on the cycle halt is sampled low; grants resume in the cycle after.
REQ-021 At most one request is accepted per cycle; reqN_ready is combinational from reqN_valid, the other valid, state and priority pointer.
REQ-022 Only one valid: that core is granted; both valid: the core named by pointer prio is granted.
REQ-023 prio updates to the non-granted core after every grant; it is unchanged in cycles without a grant.
REQ-024 mem_addr equals the granted core's reqN_addr; with no grant it equals req0_addr.
REQ-025 Accept at cycle T gives rspN_valid=1 at T+1 for exactly one cycle; no response backpressure.
REQ-026 rspN_instr and rspN_err are registered at accept and held until the next response to that core.
REQ-027 Error: reqN_addr[1:0]!=0 or reqN_addr[31:2]>=DEPTH; the response then carries rspN_err=1 and rspN_instr=NOP_INSTR.
REQ-028 Non-error responses carry rspN_err=0 and rspN_instr=mem_instr sampled at accept.
REQ-029 A response due at T+1 is delivered even if halt or the HALT state occurs at T+1.

Reset
REQ-030 While reset is high: state=BOOT, boot counter=0, prio=core0, reqN_ready=0, rspN_valid=0, rspN_instr=0, rspN_err=0, halted=0, all perf counters=0.
REQ-031 Reset during an outstanding response cancels it; rspN_valid is 0 on the cycle after reset is sampled high.

Configuration
REQ-032 Macro IMEM_ARB_PERF_EN defined: perf_grantN counts grants to core N; perf_conflict counts RUN cycles with both valids high; all saturate at 32'hFFFFFFFF.
REQ-033 Macro IMEM_ARB_PERF_EN undefined: no counter logic; perf_grant0, perf_grant1 and perf_conflict are constant 0.

Verification
REQ-034 Reset released, req0_valid=1 addr=0x8 -> req0_ready=0 for 4 cycles, then ready=1; next cycle rsp0_valid=1, rsp0_instr=mem word 2, rsp0_err=0.
REQ-035 Both valid every cycle from RUN, addr0=0x0, addr1=0x4 -> grants alternate 0,1,0,1; responses follow one cycle after each grant; perf_conflict=4 after 4 cycles (IMEM_ARB_PERF_EN defined).
REQ-036 req1_valid addr=0x6, then addr=0x80 with DEPTH=32 -> both responses have rsp1_err=1 and rsp1_instr=0x00000013.
REQ-037 Accept at T, halt=1 at T+1 -> rsp valid at T+1, halted=1 from T+2, no ready while halt high; halt=0 -> halted=0 next cycle, grants resume the cycle after.
REQ-038 Reset asserted the cycle after an accept -> no rsp_valid pulse; FSM back in BOOT; perf counters read 0.
REQ-039 Build without IMEM_ARB_PERF_EN and repeat REQ-035 -> identical grants and responses, all perf outputs 0.
